// File: rtl/dp_tap_ctrl_if.sv
// JTAG pin and boundary-scan chain signals of the oversampled TAP controller.
// The controller connects through the master modport; pins and chain through the slave modport.
interface dp_tap_ctrl_if #(
  parameter int unsigned ir_width = 4
);
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic                bsr_tdi;
  logic                bsr_tdo;
  logic                shift_dr;
  logic                clk_dr;
  logic                update_dr;
  logic                mode;
  logic [ir_width-1:0] ir_out;

  modport master (
    input  tck, tms, tdi, bsr_tdo,
    output tdo, tdo_en, bsr_tdi, shift_dr, clk_dr, update_dr, mode, ir_out
  );

  modport slave (
    output tck, tms, tdi, bsr_tdo,
    input  tdo, tdo_en, bsr_tdi, shift_dr, clk_dr, update_dr, mode, ir_out
  );
endinterface

// File: rtl/dp_tap_ctrl.sv
// Oversampled 1149.1 TAP controller: pin synchronisers, 16-state TAP FSM,
// instruction register, BYPASS/IDCODE registers and boundary-scan chain control.
module dp_tap_ctrl #(
  parameter int unsigned         ir_width    = 4,
  parameter logic [31:0]         idcode_val  = 32'h1234_5677,
  parameter logic [ir_width-1:0] extest_code = ir_width'(0),
  parameter logic [ir_width-1:0] sample_code = ir_width'(1),
  parameter logic [ir_width-1:0] idcode_code = ir_width'(2)
) (
  input  logic           iclk,
  input  logic           resetn,
  dp_tap_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  logic tck_s1, tck_s2, tck_s3;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic tck_rise, tck_fall;

  tap_state_e state, state_next;

  logic in_cap_dr, in_sh_dr, in_upd_dr;
  logic in_cap_ir, in_sh_ir, in_upd_ir;
  logic chain_sel, idcode_sel;
  logic clk_dr_c, update_dr_c;

  logic [ir_width-1:0] ir_q;
  logic [ir_width-1:0] ir_sr;
  logic                bypass_q;
  logic [31:0]         idcode_sr;
  logic                tdo_q, tdo_en_q, shift_dr_q;

  // Two-flop synchronisers; the third tck flop gives edge detection
  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      tck_s1 <= 1'b0;
      tck_s2 <= 1'b0;
      tck_s3 <= 1'b0;
      tms_s1 <= 1'b0;
      tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0;
      tdi_s2 <= 1'b0;
    end else begin
      tck_s1 <= bus.tck;
      tck_s2 <= tck_s1;
      tck_s3 <= tck_s2;
      tms_s1 <= bus.tms;
      tms_s2 <= tms_s1;
      tdi_s1 <= bus.tdi;
      tdi_s2 <= tdi_s1;
    end
  end

  assign tck_rise = tck_s2 & ~tck_s3;
  assign tck_fall = ~tck_s2 & tck_s3;

  // TAP state register
  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      state <= TLR;
    end else if (tck_rise) begin
      state <= state_next;
    end
  end

  // TAP next-state table
  always_comb begin
    state_next = state;
    unique case (state)
      TLR:    state_next = tms_s2 ? TLR    : RTI;
      RTI:    state_next = tms_s2 ? SEL_DR : RTI;
      SEL_DR: state_next = tms_s2 ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms_s2 ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms_s2 ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms_s2 ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms_s2 ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms_s2 ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms_s2 ? SEL_DR : RTI;
      SEL_IR: state_next = tms_s2 ? TLR    : CAP_IR;
      CAP_IR: state_next = tms_s2 ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms_s2 ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms_s2 ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms_s2 ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms_s2 ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms_s2 ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // State decode and chain strobes
  always_comb begin
    in_cap_dr   = 1'b0;
    in_sh_dr    = 1'b0;
    in_upd_dr   = 1'b0;
    in_cap_ir   = 1'b0;
    in_sh_ir    = 1'b0;
    in_upd_ir   = 1'b0;
    clk_dr_c    = 1'b0;
    update_dr_c = 1'b0;
    unique case (state)
      CAP_DR:  in_cap_dr = 1'b1;
      SH_DR:   in_sh_dr  = 1'b1;
      UPD_DR:  in_upd_dr = 1'b1;
      CAP_IR:  in_cap_ir = 1'b1;
      SH_IR:   in_sh_ir  = 1'b1;
      UPD_IR:  in_upd_ir = 1'b1;
      default: ;
    endcase
    if (chain_sel && tck_rise && (in_cap_dr || in_sh_dr)) begin
      clk_dr_c = 1'b1;
    end
    if (chain_sel && tck_fall && in_upd_dr) begin
      update_dr_c = 1'b1;
    end
  end

  assign chain_sel  = (ir_q == extest_code) || (ir_q == sample_code);
  assign idcode_sel = (ir_q == idcode_code);

  // Instruction shift register and active instruction
  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      ir_sr <= '0;
      ir_q  <= idcode_code;
    end else begin
      if (tck_rise && in_cap_ir) begin
        ir_sr <= ir_width'(1);
      end else if (tck_rise && in_sh_ir) begin
        ir_sr <= {tdi_s2, ir_sr[ir_width-1:1]};
      end
      if (tck_rise && (state_next == TLR)) begin
        ir_q <= idcode_code;
      end else if (tck_fall && in_upd_ir) begin
        ir_q <= ir_sr;
      end
    end
  end

  // BYPASS and IDCODE data registers
  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      bypass_q  <= 1'b0;
      idcode_sr <= idcode_val;
    end else if (tck_rise && in_cap_dr) begin
      bypass_q  <= 1'b0;
      idcode_sr <= idcode_val;
    end else if (tck_rise && in_sh_dr) begin
      bypass_q  <= tdi_s2;
      idcode_sr <= {tdi_s2, idcode_sr[31:1]};
    end
  end

  // TDO launch on the falling tck edge; shift_dr tracks SH_DR one iclk late
  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
      shift_dr_q <= 1'b0;
    end else begin
      shift_dr_q <= in_sh_dr;
      if (tck_fall) begin
        if (in_sh_dr) begin
          tdo_en_q <= 1'b1;
          if (chain_sel) begin
            tdo_q <= bus.bsr_tdo;
          end else if (idcode_sel) begin
            tdo_q <= idcode_sr[0];
          end else begin
            tdo_q <= bypass_q;
          end
        end else if (in_sh_ir) begin
          tdo_en_q <= 1'b1;
          tdo_q    <= ir_sr[0];
        end else begin
          tdo_en_q <= 1'b0;
          tdo_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.tdo       = tdo_q;
  assign bus.tdo_en    = tdo_en_q;
  assign bus.bsr_tdi   = tdi_s2;
  assign bus.shift_dr  = shift_dr_q;
  assign bus.clk_dr    = clk_dr_c;
  assign bus.update_dr = update_dr_c;
  assign bus.mode      = (ir_q == extest_code);
  assign bus.ir_out    = ir_q;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Directed-plus-random bench for dp_tap_ctrl: drives JTAG pins slowly against iclk
// and compares serial output and chain strobes with values derived from TAP rules.
module tb_dp_tap_ctrl;
  localparam int unsigned IRW    = 4;
  localparam logic [31:0] IDCODE = 32'h1234_5677;

  logic iclk = 1'b0;
  logic resetn;

  dp_tap_ctrl_if #(.ir_width(IRW)) bus ();

  dp_tap_ctrl #(.ir_width(IRW)) dut (
    .iclk   (iclk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 iclk = ~iclk;

  int compared   = 0;
  int mismatched = 0;
  int clk_dr_cap = 0;
  int clk_dr_sh  = 0;
  int upd_cnt    = 0;
  int bsr_bad    = 0;

  // Strobe counters, sampled mid-cycle
  always @(negedge iclk) begin
    if (bus.clk_dr === 1'b1) begin
      if (bus.shift_dr === 1'b1) clk_dr_sh++;
      else clk_dr_cap++;
      if (bus.bsr_tdi !== bus.tdi) bsr_bad++;
    end
    if (bus.update_dr === 1'b1) upd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full tck period; tdo reflects the falling edge on return
  task automatic pulse(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    #50 bus.tck = 1'b1;
    #50 bus.tck = 1'b0;
    #50;
  endtask

  // From RTI: capture, n shifts (last exits), update, back to RTI
  task automatic dr_scan(input logic [63:0] din, input logic [63:0] bsr, input int n,
                         output logic [63:0] dout, output logic all_en);
    dout   = '0;
    all_en = 1'b1;
    bus.bsr_tdo = bsr[0];
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = bus.tdo;
      all_en  = all_en & bus.tdo_en;
      if (i < 63) bus.bsr_tdo = bsr[i+1];
      pulse(i == n - 1, din[i]);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  task automatic ir_scan(input logic [IRW-1:0] op, output logic [IRW-1:0] dout);
    dout = '0;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < int'(IRW); i++) begin
      dout[i] = bus.tdo;
      pulse(i == int'(IRW) - 1, op[i]);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  function automatic logic is_chain(input logic [IRW-1:0] op);
    return (op == IRW'(0)) || (op == IRW'(1));
  endfunction

  // Expected serial stream of a DR scan for a given instruction
  function automatic logic [63:0] exp_dr(input logic [IRW-1:0] op, input logic [63:0] din,
                                         input logic [63:0] bsr, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) begin
      if (is_chain(op))          r[k] = bsr[k];
      else if (op == IRW'(2))    r[k] = (k < 32) ? IDCODE[k] : din[k-32];
      else                       r[k] = (k == 0) ? 1'b0 : din[k-1];
    end
    return r;
  endfunction

  initial begin
    logic [63:0]    din, bsr, dout, mask;
    logic           en;
    logic [IRW-1:0] iout, op;
    int c0, s0, u0;

    bus.tck = 1'b0; bus.tms = 1'b0; bus.tdi = 1'b0; bus.bsr_tdo = 1'b0;
    resetn = 1'b0;
    #103;
    check("rst_ir_out", bus.ir_out, 4'b0010);
    check("rst_mode", bus.mode, 1'b0);
    check("rst_tdo", bus.tdo, 1'b0);
    check("rst_tdo_en", bus.tdo_en, 1'b0);
    check("rst_shift_dr", bus.shift_dr, 1'b0);
    check("rst_strobes", {bus.clk_dr, bus.update_dr}, 2'b00);
    resetn = 1'b1;
    #20;
    repeat (10) pulse(1'b1, 1'b0);
    check("tlr_strobes", clk_dr_cap + clk_dr_sh + upd_cnt, 0);
    check("tlr_tdo_en", bus.tdo_en, 1'b0);
    check("tlr_ir_out", bus.ir_out, 4'b0010);
    pulse(1'b0, 1'b0);

    // IDCODE read, then the shifted-in data reappears
    din = {$urandom, $urandom};
    c0 = clk_dr_cap + clk_dr_sh; u0 = upd_cnt;
    dr_scan(din, 64'd0, 64, dout, en);
    check("idcode_stream", dout, exp_dr(IRW'(2), din, 64'd0, 64));
    check("idcode_en", en, 1'b1);
    check("idcode_no_strobe", (clk_dr_cap + clk_dr_sh - c0) + (upd_cnt - u0), 0);
    check("idle_tdo_en", bus.tdo_en, 1'b0);

    ir_scan(4'b0000, iout);
    check("extest_ir_cap", iout, 4'b0001);
    check("extest_ir_out", bus.ir_out, 4'b0000);
    check("extest_mode", bus.mode, 1'b1);

    // SAMPLE access of the chain
    ir_scan(4'b0001, iout);
    check("sample_ir_out", bus.ir_out, 4'b0001);
    check("sample_mode", bus.mode, 1'b0);
    bsr = 64'($urandom);
    c0 = clk_dr_cap; s0 = clk_dr_sh; u0 = upd_cnt;
    dr_scan(64'hA5, bsr, 8, dout, en);
    check("sample_tdo", dout, bsr & 64'hFF);
    check("sample_cap_clk", clk_dr_cap - c0, 1);
    check("sample_sh_clk", clk_dr_sh - s0, 8);
    check("sample_update", upd_cnt - u0, 1);
    check("sample_bsr_tdi", bsr_bad, 0);

    // Random instructions with random DR data
    for (int r = 0; r < 8; r++) begin
      op  = IRW'($urandom_range(0, 15));
      din = {$urandom, $urandom};
      bsr = {$urandom, $urandom};
      mask = 64'hFF;
      ir_scan(op, iout);
      check("rnd_ir_cap", iout, 4'b0001);
      check("rnd_ir_out", bus.ir_out, op);
      check("rnd_mode", bus.mode, op == IRW'(0));
      c0 = clk_dr_cap; s0 = clk_dr_sh; u0 = upd_cnt;
      dr_scan(din, bsr, 8, dout, en);
      check("rnd_dr_tdo", dout, exp_dr(op, din, bsr, 8) & mask);
      check("rnd_dr_en", en, 1'b1);
      check("rnd_clk_dr", (clk_dr_cap - c0) + (clk_dr_sh - s0), is_chain(op) ? 9 : 0);
      check("rnd_update", upd_cnt - u0, is_chain(op) ? 1 : 0);
    end

    // BYPASS one-bit delay
    ir_scan(4'b1111, iout);
    c0 = clk_dr_cap + clk_dr_sh; u0 = upd_cnt;
    dr_scan(64'b11101, 64'd0, 5, dout, en);
    check("bypass_tdo", dout, 64'b11010);
    check("bypass_no_strobe", (clk_dr_cap + clk_dr_sh - c0) + (upd_cnt - u0), 0);

    // Escape from SH_DR under EXTEST with tms held high
    ir_scan(4'b0000, iout);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    check("esc_shift_dr", bus.shift_dr, 1'b1);
    check("esc_mode_pre", bus.mode, 1'b1);
    repeat (5) pulse(1'b1, 1'b0);
    check("esc_mode", bus.mode, 1'b0);
    check("esc_ir_out", bus.ir_out, 4'b0010);
    check("esc_shift_dr_off", bus.shift_dr, 1'b0);

    // Reset pulsed while parked in PAU_DR under EXTEST
    pulse(1'b0, 1'b0);
    ir_scan(4'b0000, iout);
    check("pau_mode_pre", bus.mode, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    u0 = upd_cnt;
    #7 resetn = 1'b0;
    #30;
    check("pau_rst_ir_out", bus.ir_out, 4'b0010);
    check("pau_rst_mode", bus.mode, 1'b0);
    resetn = 1'b1;
    #40;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    check("pau_no_update", upd_cnt - u0, 0);
    din = {$urandom, $urandom};
    dr_scan(din, 64'd0, 32, dout, en);
    check("pau_idcode", dout, {32'd0, IDCODE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dp_tap_ctrl.md
# dp_tap_ctrl

Oversampled IEEE 1149.1 TAP controller that sits directly upstream of the debug boundary scan register chain. It samples the JTAG pins `tck`/`tms`/`tdi` on the system clock `iclk`, runs the 16-state TAP FSM, and holds the instruction register plus the BYPASS and IDCODE data registers. It generates `shift_dr`, `clk_dr`, `update_dr` and `mode` for the chain, and multiplexes the chain's serial output onto `tdo`.

## Interface
- `ir_width`, default 4: instruction register width (≥2).
- `idcode_val`, default 32'h1234_5677: IDCODE register contents; bit 0 must be 1.
- `extest_code`, default 4'b0000: EXTEST opcode (chain selected, `mode`=1).
- `sample_code`, default 4'b0001: SAMPLE/PRELOAD opcode (chain selected, `mode`=0).
- `idcode_code`, default 4'b0010: IDCODE opcode.
- Every other opcode, including all-ones, decodes as BYPASS.

Ports:
- `iclk` in 1: system clock; the only clock in the block.
- `resetn` in 1: asynchronous, active-low reset.
- `tck`, `tms`, `tdi` in 1 each: JTAG pins, asynchronous to `iclk`.
- `tdo` out 1: JTAG serial output.
- `tdo_en` out 1: `tdo` output enable.
- `bsr_tdi` out 1: serial data into the chain.
- `bsr_tdo` in 1: serial data out of the chain.
- `shift_dr` out 1: chain shift/capture select.
- `clk_dr` out 1: chain capture/shift strobe, one `iclk` wide.
- `update_dr` out 1: chain update strobe, one `iclk` wide.
- `mode` out 1: chain output-drive select.
- `ir_out` out `ir_width`: active instruction.

## Operation
**Pin synchronisation**
- `tck`, `tms` and `tdi` each pass through a 2-flop synchronizer.
- A third `tck` flop provides edge detection: `tck_rise` = s2&~s3, `tck_fall` = ~s2&s3.
- All internal activity occurs only on `tck_rise` or `tck_fall` cycles.

**TAP FSM** (advances on `tck_rise` using synced `tms`)
- States: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- Transitions follow the 1149.1 table, e.g. TLR -tms0-> RTI; SEL_IR -tms1-> TLR.
- Five consecutive `tck_rise` with `tms`=1 reach TLR from any state.

**Instruction register**
- CAP_IR on `tck_rise`: `ir_sr` loads {0…0,01}.
- SH_IR on `tck_rise`: `ir_sr` <= {tdi, ir_sr[w-1:1]}.
- UPD_IR on `tck_fall`: `ir` <= `ir_sr`.
- In TLR: `ir` = `idcode_code`.
- `ir_out` = `ir`.

**Data registers** (selected by `ir`)
- BYPASS: 1 bit; captures 0, shifts `tdi`.
- IDCODE: 32 bits; captures `idcode_val`, shifts right with `tdi` entering at MSB.
- Chain (EXTEST/SAMPLE): external; `bsr_tdi` = synced `tdi` (combinational).

**Chain control**
- `shift_dr` = registered (state==SH_DR).
- `clk_dr`: single-cycle pulse on a `tck_rise` cycle when state ∈ {CAP_DR, SH_DR} and the chain is selected.
- `update_dr`: single-cycle pulse on a `tck_fall` cycle when state==UPD_DR and the chain is selected.
- `mode` = (`ir`==`extest_code`).
- None of these strobes occur when the chain is not selected.

**TDO**
- Updated on `tck_fall`. In SH_DR or SH_IR: `tdo` <= LSB of the selected register (`bsr_tdo` for the chain) and `tdo_en` <= 1.
- Otherwise `tdo_en` <= 0 and `tdo` <= 0.

## Timing
- Reset values: state TLR, `ir` = `idcode_code`, `ir_sr` 0, bypass 0, IDCODE reg `idcode_val`, synchronizers 0.
- All outputs are 0 at reset, except `ir_out` = `idcode_code`.
- `tck_rise`/`tck_fall` assert 3 `iclk` after the pin edge. The state and registers update at the end of that cycle.
- `clk_dr` is coincident with the `tck_rise` cycle. `shift_dr` is already stable one `iclk` before each shift `clk_dr`, because SH_DR is entered on an earlier `tck_rise`.
- Capture `clk_dr` sees `shift_dr`=0.
- `tck` high and low phases must each be ≥4 `iclk` periods. Shorter phases are unsupported; edges may be lost.
- `resetn` asserted mid-operation immediately forces the reset values. Any pending strobe is dropped, and no `update_dr` is issued.
- Returning to TLR via TMS does not reset the chain contents. It only reloads `ir` and de-asserts `mode`.
- A `tck` edge coinciding with `resetn` release is ignored, because the synchronizers start at 0.

## Test plan
- **Reset:** release `resetn` → `ir_out`=4'b0010, `mode`=0, `tdo_en`=0, all strobes 0 for 10 `tck` with `tms`=1.
- **IDCODE read:** tms 0,1,0,0 then 32 shifts → `tdo` serially emits 32'h1234_5677 LSB first; `tdo_en` high only during SH_DR.
- **IR load EXTEST:** shift 0000 through SH_IR → `tdo` emits 1,0,0,0; after UPD_IR, `ir_out`=0 and `mode`=1.
- **Chain access (SAMPLE):**
  - CAP_DR → exactly one `clk_dr` with `shift_dr`=0.
  - 8 shifts of `tdi`=8'hA5 → 8 `clk_dr` pulses with `shift_dr`=1; `bsr_tdi` tracks `tdi`; `tdo` follows `bsr_tdo`.
  - UPD_DR → exactly one `update_dr`.
- **BYPASS:** `ir`=1111, shift 1,0,1,1 → `tdo` 0,1,0,1,1 (one-bit delay); zero `clk_dr`/`update_dr` pulses.
- **Escape:** in SH_DR under EXTEST, 5 `tck` with `tms`=1 → TLR, `mode`=0, `ir_out`=4'b0010. Separately, `resetn` pulsed in PAU_DR → state TLR, no `update_dr`.
